joystick_scan: RTL

Parametrised serial joystick scanner for the board-level controller path. It replaces the fixed two-pad, 8-bit reader feeding the console and `substitute_mcu` joystick inputs. It drives a chain of 74HC165-style shift registers through `joyLd`/`joyCk` and samples `joyD`. Each captured frame passes a configurable multi-frame debounce before it is published as an active-high button vector.

---
 rtl/joystick_scan.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/joystick_scan.sv
// joystick_scan
// Serial joystick scanner for a chain of 74HC165-style shift registers.
// A ce-qualified divider produces scan ticks that pace a load/shift FSM.
// Each captured frame (active-low serial data, stored active-high) passes a
// multi-frame debounce before being published on joy.

module joystick_scan #(
    parameter int CHANNELS = 2,
    parameter int BITS     = 8,
    parameter int DIV      = 4,
    parameter int GAP      = 16,
    parameter int DEBOUNCE = 2
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ce,
    output logic                     joyLd,
    output logic                     joyCk,
    input  logic                     joyD,
    output logic [CHANNELS*BITS-1:0] joy,
    output logic                     valid,
    output logic                     frame_strobe
);

    localparam int N     = CHANNELS * BITS;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int K_W   = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(N - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

    // Shift phase A holds joyCk low; phase B raises it after the bit is taken.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_A,
        S_SHIFT_B,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [GAP_W-1:0]   gap_cnt;
    logic [K_W-1:0]     k;
    logic [N-1:0]       raw;
    logic [N-1:0]       prev;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               publish;
    logic               ld_d;
    logic               ck_d;
    logic               strobe_d;

    // Tick divider: counts ce pulses 0..DIV-1; the DIV-1 cycle is the tick.
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (ce) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign tick = ce && (div_cnt == DIV_LAST);

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: every transition is tick-gated except leaving DONE.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (tick && (gap_cnt == GAP_LAST)) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (tick) begin
                    next_state = S_SHIFT_A;
                end
            end
            S_SHIFT_A: begin
                if (tick) begin
                    next_state = S_SHIFT_B;
                end
            end
            S_SHIFT_B: begin
                if (tick) begin
                    next_state = (k == K_LAST) ? S_DONE : S_SHIFT_A;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so the pins come straight from
    // flops and change only on the edge that moves the FSM.
    always_comb begin
        ld_d     = (next_state != S_LOAD);
        ck_d     = (next_state != S_SHIFT_A);
        strobe_d = (next_state == S_DONE);
    end

    // Registered chain controls and frame strobe.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joyLd        <= 1'b1;
            joyCk        <= 1'b1;
            frame_strobe <= 1'b0;
        end else begin
            joyLd        <= ld_d;
            joyCk        <= ck_d;
            frame_strobe <= strobe_d;
        end
    end

    // Gap counter, bit index and serial capture. The bit is taken on the tick
    // that ends phase A, i.e. before the rising joyCk that shifts the chain.
    // NOTE: raw is cleared on reset only to start from a known value; every
    // frame overwrites all of its bits before they are used.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            gap_cnt <= '0;
            k       <= '0;
            raw     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
                    end
                end
                S_SHIFT_A: begin
                    if (tick) begin
                        raw[k] <= ~joyD;
                    end
                end
                S_SHIFT_B: begin
                    if (tick) begin
                        k <= (k == K_LAST) ? '0 : k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Stability count for the frame just captured: grows while frames repeat,
    // saturating at DEBOUNCE-1, and restarts on any change.
    always_comb begin
        cnt_next = '0;
        if (raw == prev) begin
            cnt_next = (cnt == DEB_LAST) ? cnt : cnt + 1'b1;
        end
    end

    assign publish = (cnt_next == DEB_LAST);

    // Debounce update and publication, once per frame in DONE.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            prev  <= '0;
            cnt   <= '0;
            joy   <= '0;
            valid <= 1'b0;
        end else if (state == S_DONE) begin
            prev <= raw;
            cnt  <= cnt_next;
            if (publish) begin
                joy   <= raw;
                valid <= 1'b1;
            end
        end
    end

endmodule
